// File: rtl/lut_tile_sched.sv
`default_nettype none
// ============================================================================
// Module   : lut_tile_sched
// Brief    : Load/execute/store tile scheduler over ping-pong input and output
//            buffers. Define LUT_SCHED_PERF_EN to enable ex_stall_cycles.
// Revision : 1.0 - initial release
// ============================================================================
module lut_tile_sched #(
   parameter int TILE_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              layer_start,
   input  logic [TILE_W-1:0] layer_num_tiles,
   output logic              ld_start,
   output logic              ld_buf_sel,
   input  logic              ld_done,
   output logic              ex_start,
   output logic              ex_buf_sel,
   input  logic              ex_end,
   output logic              st_start,
   output logic              st_buf_sel,
   input  logic              st_done,
   output logic              busy,
   output logic              layer_done,
   output logic [31:0]       ex_stall_cycles
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

   localparam logic [TILE_W-1:0] c_one = TILE_W'(1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [TILE_W-1:0] r_num;
   logic [TILE_W-1:0] r_ld_idx;
   logic [TILE_W-1:0] r_ex_idx;
   logic [TILE_W-1:0] r_st_idx;
   logic [1:0]        r_in_full;
   logic [1:0]        r_out_full;
   logic [1:0]        w_in_full_nxt;
   logic [1:0]        w_out_full_nxt;
   logic              r_ld_out;
   logic              r_ex_out;
   logic              r_st_out;
   logic              r_ld_start;
   logic              r_ex_start;
   logic              r_st_start;
   logic              r_ld_sel;
   logic              r_ex_sel;
   logic              r_st_sel;
   logic              r_busy;
   logic              r_layer_done;
   logic [TILE_W-1:0] w_ld_cmp;
   logic [TILE_W-1:0] w_ex_cmp;
   logic              w_accept;
   logic              w_zero_acc;
   logic              w_ld_fin;
   logic              w_ex_fin;
   logic              w_st_fin;
   logic              w_ld_go;
   logic              w_ex_go;
   logic              w_st_go;
   logic              w_finish;

   assign w_accept   = (r_state == IDLE) && layer_start;
   assign w_zero_acc = w_accept && (layer_num_tiles == '0);

   // Completion pulses only count while the matching engine is in flight.
   assign w_ld_fin = ld_done && r_ld_out;
   assign w_ex_fin = ex_end  && r_ex_out;
   assign w_st_fin = st_done && r_st_out;

   // Issued count minus the one still in flight gives the completed count.
   assign w_ld_cmp = r_ld_idx - (r_ld_out ? c_one : '0);
   assign w_ex_cmp = r_ex_idx - (r_ex_out ? c_one : '0);

   assign w_ld_go = (r_state == RUN) && (r_ld_idx < r_num) && !r_ld_out &&
                    !r_in_full[r_ld_idx[0]];
   assign w_ex_go = (r_state == RUN) && (r_ex_idx < w_ld_cmp) && !r_ex_out &&
                    !r_out_full[r_ex_idx[0]];
   assign w_st_go = (r_state != IDLE) && (r_st_idx < w_ex_cmp) && !r_st_out;

   assign w_finish = (r_state == FLUSH) && w_st_fin && (r_st_idx == r_num);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept && !w_zero_acc) w_state_nxt = RUN;
         RUN:     if (r_ex_idx == r_num)       w_state_nxt = FLUSH;
         FLUSH:   if (w_finish)                w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // A buffer filled by a load is never the one an execute is draining,
   // so simultaneous set/clear events always touch different bits.
   always_comb begin
      w_in_full_nxt  = r_in_full;
      w_out_full_nxt = r_out_full;
      if (w_ld_fin) w_in_full_nxt[r_ld_sel] = 1'b1;
      if (w_ex_fin) begin
         w_in_full_nxt[r_ex_sel]  = 1'b0;
         w_out_full_nxt[r_ex_sel] = 1'b1;
      end
      if (w_st_fin) w_out_full_nxt[r_st_sel] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_num        <= '0;
         r_ld_idx     <= '0;
         r_ex_idx     <= '0;
         r_st_idx     <= '0;
         r_in_full    <= '0;
         r_out_full   <= '0;
         r_ld_out     <= 1'b0;
         r_ex_out     <= 1'b0;
         r_st_out     <= 1'b0;
         r_ld_start   <= 1'b0;
         r_ex_start   <= 1'b0;
         r_st_start   <= 1'b0;
         r_ld_sel     <= 1'b0;
         r_ex_sel     <= 1'b0;
         r_st_sel     <= 1'b0;
         r_busy       <= 1'b0;
         r_layer_done <= 1'b0;
      end else begin
         r_ld_start   <= w_ld_go;
         r_ex_start   <= w_ex_go;
         r_st_start   <= w_st_go;
         r_layer_done <= w_finish || w_zero_acc;
         r_busy       <= (w_state_nxt != IDLE) || w_finish || w_zero_acc;
         if (w_accept) begin
            r_num      <= layer_num_tiles;
            r_ld_idx   <= '0;
            r_ex_idx   <= '0;
            r_st_idx   <= '0;
            r_in_full  <= '0;
            r_out_full <= '0;
            r_ld_out   <= 1'b0;
            r_ex_out   <= 1'b0;
            r_st_out   <= 1'b0;
         end else begin
            r_in_full  <= w_in_full_nxt;
            r_out_full <= w_out_full_nxt;
            if (w_ld_go) begin
               r_ld_idx <= r_ld_idx + c_one;
               r_ld_sel <= r_ld_idx[0];
               r_ld_out <= 1'b1;
            end else if (w_ld_fin) begin
               r_ld_out <= 1'b0;
            end
            if (w_ex_go) begin
               r_ex_idx <= r_ex_idx + c_one;
               r_ex_sel <= r_ex_idx[0];
               r_ex_out <= 1'b1;
            end else if (w_ex_fin) begin
               r_ex_out <= 1'b0;
            end
            if (w_st_go) begin
               r_st_idx <= r_st_idx + c_one;
               r_st_sel <= r_st_idx[0];
               r_st_out <= 1'b1;
            end else if (w_st_fin) begin
               r_st_out <= 1'b0;
            end
         end
      end
   end

`ifdef LUT_SCHED_PERF_EN
   logic [31:0] r_stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall <= '0;
      end else if (w_accept) begin
         r_stall <= '0;
      end else if ((r_state == RUN) && (r_ex_idx < r_num) && !r_ex_out &&
                   !r_ex_start && (r_stall != '1)) begin
         r_stall <= r_stall + 32'd1;
      end
   end

   assign ex_stall_cycles = r_stall;
`else
   assign ex_stall_cycles = 32'd0;
`endif

   assign ld_start   = r_ld_start;
   assign ld_buf_sel = r_ld_sel;
   assign ex_start   = r_ex_start;
   assign ex_buf_sel = r_ex_sel;
   assign st_start   = r_st_start;
   assign st_buf_sel = r_st_sel;
   assign busy       = r_busy;
   assign layer_done = r_layer_done;
endmodule
`default_nettype wire

// File: tb/tb_lut_tile_sched.sv
`default_nettype none
// Bench for lut_tile_sched: bench-side engines with per-tile latencies, checked
// against an event-time model of the tile pipeline.
module tb_lut_tile_sched;
   localparam int TW   = 16;
   localparam int MAXT = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          layer_start;
   logic [TW-1:0] layer_num_tiles;
   logic          ld_start, ld_buf_sel, ld_done;
   logic          ex_start, ex_buf_sel, ex_end;
   logic          st_start, st_buf_sel, st_done;
   logic          busy, layer_done;
   logic [31:0]   ex_stall_cycles;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lut_tile_sched #(.TILE_W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .layer_start(layer_start),
      .layer_num_tiles(layer_num_tiles),
      .ld_start(ld_start), .ld_buf_sel(ld_buf_sel), .ld_done(ld_done),
      .ex_start(ex_start), .ex_buf_sel(ex_buf_sel), .ex_end(ex_end),
      .st_start(st_start), .st_buf_sel(st_buf_sel), .st_done(st_done),
      .busy(busy), .layer_done(layer_done), .ex_stall_cycles(ex_stall_cycles)
   );

   int ld_lat[MAXT], ex_lat[MAXT], st_lat[MAXT];
   int ld_s[MAXT], ld_d[MAXT], ex_s[MAXT], ex_e[MAXT], st_s[MAXT], st_d[MAXT];
   logic [MAXT-1:0] ld_b, ex_b, st_b;
   int n_ld, n_ex, n_st, n_done, done_cyc;
   int busy_cnt, busy_first, busy_last, sel_err;
   logic [8:0] post_rst;
   int m_ld_s[MAXT], m_ld_d[MAXT], m_ex_s[MAXT], m_ex_e[MAXT];
   int m_st_s[MAXT], m_st_d[MAXT];
   int m_done, m_stall;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic set_lat(input int l, input int e, input int s);
      for (int i = 0; i < MAXT; i++) begin
         ld_lat[i] = l; ex_lat[i] = e; st_lat[i] = s;
      end
   endtask

   // Event-time model (cycle 0 = layer_start): an operation may start two
   // cycles after the last event it depends on (one to register the event,
   // one for the registered start pulse).
   task automatic build_model(input int n);
      int busy_ex;
      for (int i = 0; i < n; i++) begin
         m_ld_s[i] = 2;
         if (i > 0) m_ld_s[i] = max2(m_ld_s[i], m_ld_d[i-1] + 2);
         if (i > 1) m_ld_s[i] = max2(m_ld_s[i], m_ex_e[i-2] + 2);
         m_ld_d[i] = m_ld_s[i] + ld_lat[i];
         m_ex_s[i] = m_ld_d[i] + 2;
         if (i > 0) m_ex_s[i] = max2(m_ex_s[i], m_ex_e[i-1] + 2);
         if (i > 1) m_ex_s[i] = max2(m_ex_s[i], m_st_d[i-2] + 2);
         m_ex_e[i] = m_ex_s[i] + ex_lat[i];
         m_st_s[i] = m_ex_e[i] + 2;
         if (i > 0) m_st_s[i] = max2(m_st_s[i], m_st_d[i-1] + 2);
         m_st_d[i] = m_st_s[i] + st_lat[i];
      end
      m_done  = (n == 0) ? 1 : m_st_d[n-1] + 1;
      m_stall = 0;
      if (n > 0) begin
         busy_ex = 0;
         for (int i = 0; i < n - 1; i++) busy_ex += m_ex_e[i] - m_ex_s[i] + 1;
         m_stall = (m_ex_s[n-1] - 1) - busy_ex;
      end
   endtask

   function automatic int timing_err(input int n);
      int e = 0;
      for (int i = 0; i < n; i++)
         if (ld_s[i] != m_ld_s[i] || ex_s[i] != m_ex_s[i] || st_s[i] != m_st_s[i]) e++;
      return e;
   endfunction

   function automatic logic [MAXT-1:0] alt_sel(input int n);
      logic [MAXT-1:0] v = '0;
      for (int i = 0; i < n; i++) v[i] = (i % 2 == 1);
      return v;
   endfunction

   function automatic int stall_exp();
`ifdef LUT_SCHED_PERF_EN
      return m_stall;
`else
      return 0;
`endif
   endfunction

   // Drives one layer with bench-side engines; optional injected ignored
   // layer_start, spurious st_done and a one-cycle reset (-1 disables).
   task automatic run_layer(input int n, input int ign_cyc, input int spur_cyc, input int rst_cyc);
      int   ld_pend = 0, ex_pend = 0, st_pend = 0;
      bit   ldb = 0, exb = 0, stb = 0;
      logic ld_sel = 0, ex_sel = 0, st_sel = 0;
      n_ld = 0; n_ex = 0; n_st = 0; n_done = 0; done_cyc = -1;
      busy_cnt = 0; busy_first = -1; busy_last = -1; sel_err = 0;
      post_rst = '1; ld_b = '0; ex_b = '0; st_b = '0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         layer_start = 0; ld_done = 0; ex_end = 0; st_done = 0; rst_n = 1;
         if (k == 0) begin layer_start = 1; layer_num_tiles = TW'(n); end
         if (ldb && ld_buf_sel !== ld_sel) sel_err++;
         if (exb && ex_buf_sel !== ex_sel) sel_err++;
         if (stb && st_buf_sel !== st_sel) sel_err++;
         if (ld_start === 1'b1) begin
            ld_s[n_ld % MAXT] = k; ld_b[n_ld % MAXT] = ld_buf_sel;
            ld_pend = k + ld_lat[n_ld % MAXT]; ldb = 1; ld_sel = ld_buf_sel; n_ld++;
         end
         if (ex_start === 1'b1) begin
            ex_s[n_ex % MAXT] = k; ex_b[n_ex % MAXT] = ex_buf_sel;
            ex_pend = k + ex_lat[n_ex % MAXT]; exb = 1; ex_sel = ex_buf_sel; n_ex++;
         end
         if (st_start === 1'b1) begin
            st_s[n_st % MAXT] = k; st_b[n_st % MAXT] = st_buf_sel;
            st_pend = k + st_lat[n_st % MAXT]; stb = 1; st_sel = st_buf_sel; n_st++;
         end
         if (layer_done === 1'b1) begin n_done++; done_cyc = k; end
         if (busy === 1'b1) begin
            busy_cnt++; if (busy_first < 0) busy_first = k; busy_last = k;
         end
         if (ldb && k == ld_pend) begin ld_done = 1; ld_d[(n_ld-1) % MAXT] = k; ldb = 0; end
         if (exb && k == ex_pend) begin ex_end  = 1; ex_e[(n_ex-1) % MAXT] = k; exb = 0; end
         if (stb && k == st_pend) begin st_done = 1; st_d[(n_st-1) % MAXT] = k; stb = 0; end
         if (k == spur_cyc && !stb) st_done = 1;
         if (k == ign_cyc) begin layer_start = 1; layer_num_tiles = TW'(5); end
         if (k == rst_cyc) begin rst_n = 0; ldb = 0; exb = 0; stb = 0; end
         if (rst_cyc >= 0 && k == rst_cyc + 1)
            post_rst = {ld_start, ld_buf_sel, ex_start, ex_buf_sel, st_start,
                        st_buf_sel, busy, layer_done, |ex_stall_cycles};
         if ((rst_cyc < 0 && n_done > 0 && k >= done_cyc + 2) ||
             (rst_cyc >= 0 && k >= rst_cyc + 6)) break;
      end
      @(negedge clk);
      layer_start = 0; ld_done = 0; ex_end = 0; st_done = 0; rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0; layer_start = 0; layer_num_tiles = '0;
      ld_done = 0; ex_end = 0; st_done = 0;
      repeat (3) @(negedge clk);
      total++;
      if ({ld_start, ld_buf_sel, ex_start, ex_buf_sel, st_start, st_buf_sel, busy, layer_done} !== 8'h00) begin
         bad++; $display("FAIL reset_outputs: got %b want 00000000",
            {ld_start, ld_buf_sel, ex_start, ex_buf_sel, st_start, st_buf_sel, busy, layer_done});
      end
      total++;
      if (ex_stall_cycles !== 32'd0) begin
         bad++; $display("FAIL reset_stall: got %0d want 0", ex_stall_cycles);
      end
      rst_n = 1;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, ld_start, layer_done} !== 3'b000) begin
         bad++; $display("FAIL reset_idle: got %b want 000", {busy, ld_start, layer_done});
      end
   endtask

   task automatic test_single_tile();
      set_lat(3, 3, 3); run_layer(1, -1, -1, -1); build_model(1);
      total++;
      if (n_ld != 1 || n_ex != 1 || n_st != 1) begin
         bad++; $display("FAIL single_counts: ld=%0d ex=%0d st=%0d want 1 each", n_ld, n_ex, n_st);
      end
      total++;
      if ({ld_b, ex_b, st_b} !== '0) begin
         bad++; $display("FAIL single_bufsel: got %b/%b/%b want 0", ld_b[0], ex_b[0], st_b[0]);
      end
      total++;
      if (timing_err(1) != 0) begin
         bad++; $display("FAIL single_timing: ld=%0d ex=%0d st=%0d want %0d %0d %0d",
            ld_s[0], ex_s[0], st_s[0], m_ld_s[0], m_ex_s[0], m_st_s[0]);
      end
      total++;
      if (n_done != 1 || done_cyc != m_done) begin
         bad++; $display("FAIL single_done: count=%0d cyc=%0d want 1 at %0d", n_done, done_cyc, m_done);
      end
      total++;
      if (busy_first != 1 || busy_last != m_done || busy_cnt != m_done) begin
         bad++; $display("FAIL single_busy: first=%0d last=%0d cnt=%0d want 1 %0d %0d",
            busy_first, busy_last, busy_cnt, m_done, m_done);
      end
      total++;
      if (ex_stall_cycles !== 32'(stall_exp())) begin
         bad++; $display("FAIL single_stall: got %0d want %0d", ex_stall_cycles, stall_exp());
      end
   endtask

   task automatic test_zero_latency();
      set_lat(0, 0, 0); run_layer(4, -1, -1, -1); build_model(4);
      total++;
      if (ld_b !== alt_sel(4) || ex_b !== alt_sel(4) || st_b !== alt_sel(4)) begin
         bad++; $display("FAIL zl_bufsel: ld=%b ex=%b st=%b want %b", ld_b, ex_b, st_b, alt_sel(4));
      end
      total++;
      if (ld_s[2] <= ex_e[0]) begin
         bad++; $display("FAIL zl_ld2_order: ld2 start=%0d ex0 end=%0d want later", ld_s[2], ex_e[0]);
      end
      total++;
      if (timing_err(4) != 0 || sel_err != 0) begin
         bad++; $display("FAIL zl_timing: tile errs=%0d sel errs=%0d want 0", timing_err(4), sel_err);
      end
      total++;
      if (n_done != 1 || done_cyc != m_done) begin
         bad++; $display("FAIL zl_done: count=%0d cyc=%0d want 1 at %0d", n_done, done_cyc, m_done);
      end
      total++;
      if (ex_stall_cycles !== 32'(stall_exp())) begin
         bad++; $display("FAIL zl_stall: got %0d want %0d", ex_stall_cycles, stall_exp());
      end
   endtask

   task automatic test_store_backpressure();
      set_lat(1, 1, 50); run_layer(3, -1, -1, -1); build_model(3);
      total++;
      if (ex_s[2] <= st_d[0]) begin
         bad++; $display("FAIL bp_ex2_wait: ex2 start=%0d st0 done=%0d want later", ex_s[2], st_d[0]);
      end
      total++;
      if (timing_err(3) != 0 || n_done != 1 || done_cyc != m_done) begin
         bad++; $display("FAIL bp_timing: tile errs=%0d done=%0d@%0d want 0, 1@%0d",
            timing_err(3), n_done, done_cyc, m_done);
      end
   endtask

   task automatic test_same_cycle();
      set_lat(3, 3, 2); run_layer(2, -1, 3, -1); build_model(2);
      total++;
      if (ld_d[1] != ex_e[0]) begin
         bad++; $display("FAIL sc_coincide: ld1 done=%0d ex0 end=%0d want equal", ld_d[1], ex_e[0]);
      end
      total++;
      if (timing_err(2) != 0 || n_st != 2) begin
         bad++; $display("FAIL sc_timing: tile errs=%0d stores=%0d want 0, 2", timing_err(2), n_st);
      end
      total++;
      if (n_done != 1 || done_cyc != m_done) begin
         bad++; $display("FAIL sc_done: count=%0d cyc=%0d want 1 at %0d", n_done, done_cyc, m_done);
      end
   endtask

   task automatic test_zero_tiles();
      set_lat(2, 2, 2); run_layer(0, -1, -1, -1); build_model(0);
      total++;
      if (n_done != 1 || done_cyc != 1) begin
         bad++; $display("FAIL zero_done: count=%0d cyc=%0d want 1 at 1", n_done, done_cyc);
      end
      total++;
      if (n_ld + n_ex + n_st != 0 || busy_cnt != 1 || busy_first != 1) begin
         bad++; $display("FAIL zero_idle: starts=%0d busy_cnt=%0d busy_first=%0d want 0 1 1",
            n_ld + n_ex + n_st, busy_cnt, busy_first);
      end
      run_layer(3, 4, -1, -1); build_model(3);
      total++;
      if (n_ld != 3 || timing_err(3) != 0 || n_done != 1 || done_cyc != m_done) begin
         bad++; $display("FAIL ignore_start: loads=%0d tile errs=%0d done=%0d@%0d want 3 0 1@%0d",
            n_ld, timing_err(3), n_done, done_cyc, m_done);
      end
   endtask

   task automatic test_reset_mid();
      set_lat(2, 2, 2); run_layer(3, -1, -1, 6);
      total++;
      if (post_rst !== 9'd0) begin
         bad++; $display("FAIL midrst_outputs: got %b want 000000000", post_rst);
      end
      total++;
      if (n_done != 0 || busy_last != 6) begin
         bad++; $display("FAIL midrst_abandon: done=%0d busy_last=%0d want 0 6", n_done, busy_last);
      end
      run_layer(2, -1, -1, -1); build_model(2);
      total++;
      if (timing_err(2) != 0 || n_done != 1 || done_cyc != m_done) begin
         bad++; $display("FAIL midrst_relayer: tile errs=%0d done=%0d@%0d want 0 1@%0d",
            timing_err(2), n_done, done_cyc, m_done);
      end
      total++;
      if (ex_stall_cycles !== 32'(stall_exp())) begin
         bad++; $display("FAIL midrst_stall: got %0d want %0d", ex_stall_cycles, stall_exp());
      end
   endtask

   task automatic test_random();
      int n;
      for (int r = 0; r < 6; r++) begin
         n = int'($urandom_range(1, 8));
         for (int i = 0; i < MAXT; i++) begin
            ld_lat[i] = int'($urandom_range(0, 6));
            ex_lat[i] = int'($urandom_range(0, 6));
            st_lat[i] = int'($urandom_range(0, 6));
         end
         run_layer(n, -1, -1, -1); build_model(n);
         total++;
         if (timing_err(n) != 0 || sel_err != 0 || n_ld != n || n_ex != n || n_st != n) begin
            bad++; $display("FAIL rand%0d_timing: n=%0d tile errs=%0d sel errs=%0d starts=%0d/%0d/%0d",
               r, n, timing_err(n), sel_err, n_ld, n_ex, n_st);
         end
         total++;
         if (n_done != 1 || done_cyc != m_done || busy_last != m_done) begin
            bad++; $display("FAIL rand%0d_done: done=%0d@%0d busy_last=%0d want 1@%0d",
               r, n_done, done_cyc, busy_last, m_done);
         end
         total++;
         if (ex_stall_cycles !== 32'(stall_exp())) begin
            bad++; $display("FAIL rand%0d_stall: got %0d want %0d", r, ex_stall_cycles, stall_exp());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_tile();
      test_zero_latency();
      test_store_backpressure();
      test_same_cycle();
      test_zero_tiles();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/lut_tile_sched.md
LUT_TILE_SCHED -- requirements
Module: lut_tile_sched

Interface
REQ-001 SHALL have parameter TILE_W, default 16, tile-count and tile-index width.
REQ-002 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port layer_start  input  1  single-cycle pulse requesting a layer run.
REQ-005 SHALL have port layer_num_tiles  input  TILE_W  tile count N, sampled when layer_start is accepted.
REQ-006 SHALL have port ld_start / ld_buf_sel  output  1 / 1  load-engine start pulse and target input ping-pong buffer.
REQ-007 SHALL have port ld_done  input  1  load-engine completion pulse.
REQ-008 SHALL have port ex_start / ex_buf_sel  output  1 / 1  pulse driving bs_ex_tile_start, and the input/output buffer pair in use.
REQ-009 SHALL have port ex_end  input  1  bs_ex_tile_end from the execute controller.
REQ-010 SHALL have port st_start / st_buf_sel  output  1 / 1  store-engine start pulse and source output buffer.
REQ-011 SHALL have port st_done  input  1  store-engine completion pulse.
REQ-012 SHALL have port busy / layer_done  output  1 / 1  run in progress; single-cycle completion pulse.
REQ-013 SHALL have port ex_stall_cycles  output  32  performance counter (see Configuration).

Function
REQ-014 SHALL implement states IDLE, RUN, FLUSH: IDLE->RUN on accepted layer_start with N>0; RUN->FLUSH once N executes have been issued; FLUSH->IDLE when the N-th st_done arrives, with layer_done pulsed in that same transition cycle.
REQ-015 SHALL accept layer_start only in IDLE; layer_start in RUN/FLUSH is ignored.
REQ-016 SHALL, for N=0, pulse layer_done exactly one cycle after layer_start, issue no starts, and remain in IDLE.
REQ-017 SHALL keep three TILE_W next-index counters (ld_idx, ex_idx, st_idx), zeroed on accepting layer_start; tile i uses buffer i[0].
REQ-018 SHALL keep in_full[1:0] and out_full[1:0] flags plus one outstanding flag per engine; at most one operation per engine in flight.
REQ-019 SHALL issue ld_start when RUN, ld_idx<N, no load outstanding, and in_full[ld_idx[0]]==0.
REQ-020 SHALL issue ex_start when RUN, ex_idx<ld-completed count, no execute outstanding, and out_full[ex_idx[0]]==0.
REQ-021 SHALL issue st_start when st_idx<ex-completed count and no store outstanding.
REQ-022 SHALL register all outputs; every start pulse is exactly one cycle wide and is issued no earlier than the cycle after its enabling condition becomes true.
REQ-023 SHALL, on ld_done, set in_full[ld_buf]; on ex_end, clear in_full[ex_buf] and set out_full[ex_buf]; on st_done, clear out_full[st_buf].
REQ-024 SHALL apply every combination of ld_done, ex_end and st_done arriving in the same cycle, with none lost.
REQ-025 SHALL ignore ld_done/ex_end/st_done when the matching engine has no operation outstanding.
REQ-026 SHALL hold busy high from the cycle after layer_start is accepted through the layer_done cycle inclusive.
REQ-027 SHALL hold *_buf_sel stable from the start pulse until the matching done/end.

Reset
REQ-028 SHALL, while rst_n==0, force state IDLE; all counters, flags and outputs to 0; ex_stall_cycles to 0.
REQ-029 SHALL abandon any in-flight layer on reset mid-run, with no layer_done pulse.

Configuration
REQ-030 SHALL, with LUT_SCHED_PERF_EN defined, count cycles in RUN where ex_idx<N, no execute is outstanding and ex_start is not asserted; clear on accepted layer_start; saturate at 2^32-1.
REQ-031 SHALL, without LUT_SCHED_PERF_EN, drive ex_stall_cycles constant 0 with no counter logic.

Verification
REQ-032 SHALL cover: N=1, done pulses 3 cycles after each start -> one ld/ex/st start each on buffer 0, layer_done once, busy low afterwards.
REQ-033 SHALL cover: N=4, zero-latency engines -> buf_sel order 0,1,0,1 on every engine; the load of tile 2 does not start before ex_end of tile 0.
REQ-034 SHALL cover: N=3, store held 50 cycles -> ex_start for tile 2 waits for st_done of tile 0.
REQ-035 SHALL cover: ld_done and ex_end in the same cycle, then a spurious st_done with no store outstanding -> both flags update, spurious pulse ignored, final layer_done count still 1.
REQ-036 SHALL cover: N=0 -> layer_done exactly 1 cycle after layer_start, no starts; layer_start during RUN ignored.
REQ-037 SHALL cover: rst_n low mid-layer for 1 cycle -> all outputs 0, IDLE; a new N=2 layer then completes normally; with LUT_SCHED_PERF_EN, ex_stall_cycles matches the bench's stall-cycle count.
